// File: rtl/spi_timing_gen.sv
// SPI timing generator: free-running sclk and display clock dividers with edge strobes,
// plus a bit/byte counter that advances on sclk rising edges while a transfer is active.
module spi_timing_gen #(
  parameter int unsigned SCLK_HALF     = 10,
  parameter int unsigned DISP_HALF     = 50000,
  parameter int unsigned BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_en,
  output logic       sclk,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic [2:0] bit_cnt,
  output logic [1:0] byte_cnt,
  output logic       byte_done,
  output logic       disp_clk,
  output logic       disp_tick
);

  localparam int unsigned SclkW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned DispW = (DISP_HALF > 1) ? $clog2(DISP_HALF) : 1;
  localparam logic [SclkW-1:0] SclkLast = SclkW'(SCLK_HALF - 1);
  localparam logic [DispW-1:0] DispLast = DispW'(DISP_HALF - 1);
  localparam logic [2:0]       BitLast  = 3'(BITS_PER_BYTE - 1);

  logic [SclkW-1:0] sclk_cnt_q;
  logic [DispW-1:0] disp_cnt_q;

  // Strobes are set in the same edge as the toggle, so they coincide with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_cnt_q <= '0;
      sclk       <= 1'b0;
      sclk_rise  <= 1'b0;
      sclk_fall  <= 1'b0;
    end else begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      if (sclk_cnt_q == SclkLast) begin
        sclk_cnt_q <= '0;
        sclk       <= ~sclk;
        sclk_rise  <= ~sclk;
        sclk_fall  <= sclk;
      end else begin
        sclk_cnt_q <= sclk_cnt_q + SclkW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_cnt_q <= '0;
      disp_clk   <= 1'b0;
      disp_tick  <= 1'b0;
    end else begin
      disp_tick <= 1'b0;
      if (disp_cnt_q == DispLast) begin
        disp_cnt_q <= '0;
        disp_clk   <= ~disp_clk;
        disp_tick  <= ~disp_clk;
      end else begin
        disp_cnt_q <= disp_cnt_q + DispW'(1);
      end
    end
  end

  // Clearing on count_en low takes priority over an advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_done <= 1'b0;
    end else if (!count_en) begin
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (sclk_rise) begin
        if (bit_cnt == BitLast) begin
          bit_cnt   <= '0;
          byte_cnt  <= byte_cnt + 2'd1;
          byte_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_timing_gen.sv
// Bench for spi_timing_gen: cycle scoreboard against a time-based reference model, a table of
// counting phases, and hand sequences for reset and count_en corner cases.
module tb_spi_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       count_en;
  logic       sclk, sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic       byte_done, disp_clk, disp_tick;

  int n_checks = 0;
  int n_fail   = 0;

  spi_timing_gen #(
    .SCLK_HALF    (10),
    .DISP_HALF    (4),
    .BITS_PER_BYTE(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (count_en),
    .sclk     (sclk),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .bit_cnt  (bit_cnt),
    .byte_cnt (byte_cnt),
    .byte_done(byte_done),
    .disp_clk (disp_clk),
    .disp_tick(disp_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] dut_vec();
    return {sclk, sclk_rise, sclk_fall, bit_cnt, byte_cnt, byte_done, disp_clk, disp_tick};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: divider outputs derived from edges since reset release.
  int          t      = 0;
  logic        m_rise = 1'b0;
  logic [2:0]  m_bit  = '0;
  logic [1:0]  m_byte = '0;
  logic        m_done = 1'b0;
  logic [10:0] sb_q[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = 0; m_rise = 1'b0; m_bit = '0; m_byte = '0; m_done = 1'b0;
      sb_q.delete();
    end else begin
      m_done = 1'b0;
      if (!count_en) begin
        m_bit = '0; m_byte = '0;
      end else if (m_rise) begin
        if (m_bit == 3'd7) begin
          m_bit = '0; m_byte = m_byte + 2'd1; m_done = 1'b1;
        end else begin
          m_bit = m_bit + 3'd1;
        end
      end
      t++;
      m_rise = (t % 20 == 10);
      sb_q.push_back({1'(((t / 10) % 2) == 1), m_rise, 1'(t % 20 == 0), m_bit, m_byte, m_done,
                      1'(((t / 4) % 2) == 1), 1'(t % 8 == 4)});
    end
  end

  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) check("scoreboard", int'(dut_vec()), int'(sb_q.pop_front()));
  end

  typedef struct {
    bit en;
    int rises;
    int exp_bit;
    int exp_byte;
    int exp_done;
  } row_t;

  row_t rows[5];

  initial begin
    int first_hi, n_rise, n_tick, got, dn, cyc;
    rows[0] = '{en: 1'b1, rises: 8,  exp_bit: 0, exp_byte: 1, exp_done: 1};
    rows[1] = '{en: 1'b1, rises: 24, exp_bit: 0, exp_byte: 0, exp_done: 3};
    rows[2] = '{en: 1'b1, rises: 3,  exp_bit: 3, exp_byte: 0, exp_done: 0};
    rows[3] = '{en: 1'b0, rises: 1,  exp_bit: 0, exp_byte: 0, exp_done: 0};
    rows[4] = '{en: 1'b1, rises: 21, exp_bit: 5, exp_byte: 2, exp_done: 2};

    rst_n = 1'b0;
    count_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", int'(dut_vec()), 0);
    #3 rst_n = 1'b1;

    // Free-run from reset: first sclk high after edge 10, 10 rises and 25 disp ticks in 200.
    first_hi = -1; n_rise = 0; n_tick = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (sclk_rise) n_rise++;
      if (disp_tick) n_tick++;
      if (sclk && first_hi < 0) first_hi = k;
    end
    check("first sclk high edge", first_hi, 10);
    check("sclk_rise count", n_rise, 10);
    check("disp_tick count", n_tick, 25);

    for (int i = 0; i < 5; i++) begin
      count_en = rows[i].en;
      got = 0; dn = 0; cyc = 0;
      while (got < rows[i].rises && cyc < rows[i].rises * 20 + 40) begin
        @(negedge clk);
        cyc++;
        if (byte_done) dn++;
        if (sclk_rise) got++;
      end
      check($sformatf("row%0d rise budget", i), got, rows[i].rises);
      @(negedge clk);
      if (byte_done) dn++;
      check($sformatf("row%0d bit_cnt", i), int'(bit_cnt), rows[i].exp_bit);
      check($sformatf("row%0d byte_cnt", i), int'(byte_cnt), rows[i].exp_byte);
      check($sformatf("row%0d byte_done pulses", i), dn, rows[i].exp_done);
    end

    // Drop count_en at bit 5 / byte 2: cleared on the next edge, no byte_done.
    count_en = 1'b0;
    @(negedge clk);
    check("drop bit_cnt", int'(bit_cnt), 0);
    check("drop byte_cnt", int'(byte_cnt), 0);
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (byte_done) dn++;
    end
    check("drop byte_done", dn, 0);

    // Mid-byte reset takes effect without a clock edge.
    count_en = 1'b1;
    repeat (57) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("async reset outputs", int'(dut_vec()), 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    first_hi = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sclk && first_hi < 0) first_hi = k;
    end
    check("first sclk high after reset", first_hi, 10);
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_timing_gen.md
SPI_TIMING_GEN -- requirements
Module: spi_timing_gen

Interface
REQ-001 Parameter SCLK_HALF, default 10: clk cycles per sclk half-period (100 MHz -> 5 MHz).
REQ-002 Parameter DISP_HALF, default 50000: clk cycles per disp_clk half-period (100 MHz -> 1 kHz).
REQ-003 Parameter BITS_PER_BYTE, default 8: sclk rising edges per counted byte.
REQ-004 clk  input  1  sole clock, 100 MHz; every register is clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 count_en  input  1  byte-counter enable (transfer active); low clears the counters.
REQ-007 sclk  output  1  divided serial clock, 50% duty.
REQ-008 sclk_rise  output  1  one-clk strobe in the cycle sclk first reads 1.
REQ-009 sclk_fall  output  1  one-clk strobe in the cycle sclk first reads 0.
REQ-010 bit_cnt  output  3  bit position within the current byte.
REQ-011 byte_cnt  output  2  completed-byte count.
REQ-012 byte_done  output  1  one-clk strobe when a byte completes.
REQ-013 disp_clk  output  1  display-multiplex clock, 50% duty.
REQ-014 disp_tick  output  1  one-clk strobe on each disp_clk rising edge.

Function
REQ-015 The sclk divider SHALL use a counter 0..SCLK_HALF-1 that increments every clk cycle.
REQ-016 When the sclk counter equals SCLK_HALF-1, it SHALL wrap to 0 and sclk SHALL toggle in the same edge.
REQ-017 sclk period SHALL be 2*SCLK_HALF clk cycles, giving 20 cycles and 5 MHz at the default.
REQ-018 sclk_rise and sclk_fall SHALL be registered with the toggle; each is high for exactly one clk cycle per edge and never high together.
REQ-019 The disp_clk divider SHALL follow REQ-015..REQ-017 using DISP_HALF, and disp_tick SHALL follow REQ-018 for rising edges only.
REQ-020 The disp_clk divider SHALL run independently of count_en.
REQ-021 The byte counter SHALL advance only on clk cycles where sclk_rise=1 and count_en=1.
REQ-022 On each advance, bit_cnt SHALL increment.
REQ-023 When bit_cnt=BITS_PER_BYTE-1 on an advance, bit_cnt SHALL go to 0, byte_cnt SHALL increment, and byte_done SHALL pulse on the next cycle.
REQ-024 byte_cnt SHALL wrap from 3 to 0.
REQ-025 When count_en=0, bit_cnt and byte_cnt SHALL clear to 0 on the next clk edge, and byte_done SHALL be 0.
REQ-026 Clearing has priority over an advance in the same cycle.
REQ-027 Both dividers SHALL free-run continuously; count_en does not gate sclk.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-029 While rst_n=0, all counters SHALL be 0 and sclk, disp_clk and all strobes SHALL be 0.
REQ-030 After rst_n rises, the first sclk rising edge SHALL occur on the SCLK_HALF-th clk edge (10th at default).
REQ-031 After rst_n rises, the first disp_clk rising edge SHALL occur on the DISP_HALF-th clk edge.
REQ-032 Asserting rst_n mid-operation SHALL return every output to its reset value immediately, without waiting for a clk edge.

Verification
REQ-033 Release reset, run 200 clk cycles -> sclk high on cycles 10-19, 30-39, ...; 10 sclk_rise pulses; period 20.
REQ-034 count_en=1 for 8 sclk rises -> bit_cnt 0..7 then 0, byte_cnt=1, one byte_done pulse.
REQ-035 count_en=1 for 32 sclk rises -> byte_cnt goes 1, 2, 3, 0; 4 byte_done pulses.
REQ-036 count_en dropped at bit_cnt=5, byte_cnt=2 -> both 0 on the next clk edge; no byte_done.
REQ-037 rst_n pulsed low mid-byte -> all outputs 0 asynchronously; sclk restarts with its first rise 10 cycles after release.
REQ-038 DISP_HALF=4 override -> disp_clk period 8 cycles; disp_tick once per period.
